// File: rtl/read_deal.sv
// Frame reader: takes completed frames from a standard (non-FWFT) FIFO and emits
// byte_num bytes per frame, sized by the current down-gear code, with abort on gear change.
module read_deal #(
    parameter int unsigned PEND_W = 2
) (
    input  logic       clk163m84,
    input  logic       rst_n,
    input  logic [7:0] r_down_gear_r,
    input  logic [7:0] r_down_gear_rr,
    input  logic       wr_ml_end,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_dout,
    output logic       fifo_rd_en,
    output logic [7:0] data_out,
    output logic       data_out_valid,
    output logic       frame_start,
    output logic       frame_end,
    output logic       frame_abort,
    output logic       pend_ovf,
    output logic       rd_busy
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 16;
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_READ  = 2'd1,
        R_DRAIN = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    byte_num_q, byte_num_d;
    logic [CNT_W-1:0]    frame_len_q, frame_len_d;
    logic [CNT_W-1:0]    rd_cnt_q, rd_cnt_d;
    logic [PEND_W-1:0]   pend_cnt_q, pend_cnt_d;
    logic                drain_q, drain_d;
    logic                rd_en_d1_q, rd_en_d1_d;
    logic                last_d1_q, last_d1_d;
    logic [DATA_W-1:0]   data_out_q, data_out_d;
    logic                data_out_valid_q, data_out_valid_d;
    logic                frame_start_q, frame_start_d;
    logic                frame_end_q, frame_end_d;
    logic                frame_abort_q, frame_abort_d;
    logic                pend_ovf_q, pend_ovf_d;
    logic                rd_busy_q, rd_busy_d;

    logic gear_chg_c, pend_nz_c, take_c, start_c, abort_c, rd_en_c, last_rd_c;

    // Frame length in bytes for each down-gear code; unknown codes mean "no frame".
    function automatic logic [CNT_W-1:0] gear_bytes(input logic [7:0] gear);
        case (gear)
            8'h52:                                gear_bytes = CNT_W'(48);
            8'h51:                                gear_bytes = CNT_W'(20);
            8'h4F, 8'h4E:                         gear_bytes = CNT_W'(40);
            8'h4D, 8'h4C:                         gear_bytes = CNT_W'(80);
            8'h4B, 8'h4A:                         gear_bytes = CNT_W'(160);
            8'h49:                                gear_bytes = CNT_W'(320);
            8'h48, 8'h47, 8'h46, 8'h45, 8'h44:    gear_bytes = CNT_W'(160);
            8'h43:                                gear_bytes = CNT_W'(320);
            8'h42, 8'h41:                         gear_bytes = CNT_W'(480);
            default:                              gear_bytes = CNT_W'(0);
        endcase
    endfunction

    always_comb begin
        gear_chg_c = (r_down_gear_r != r_down_gear_rr);
        pend_nz_c  = (pend_cnt_q != '0);
        take_c     = (state_q == R_IDLE) && !gear_chg_c && pend_nz_c;
        start_c    = take_c && (byte_num_q != '0);
        abort_c    = (state_q != R_IDLE) && gear_chg_c;
        rd_en_c    = rst_n && (state_q == R_READ) && !fifo_empty && !gear_chg_c;
        last_rd_c  = rd_en_c && (rd_cnt_q == frame_len_q - CNT_W'(1));
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d          = state_q;
        byte_num_d       = gear_bytes(r_down_gear_rr);
        frame_len_d      = frame_len_q;
        rd_cnt_d         = rd_cnt_q;
        pend_cnt_d       = pend_cnt_q;
        drain_d          = drain_q;
        rd_en_d1_d       = rd_en_c;
        last_d1_d        = last_rd_c;
        data_out_d       = rd_en_d1_q ? fifo_dout : data_out_q;
        data_out_valid_d = rd_en_d1_q;
        frame_start_d    = start_c;
        frame_end_d      = last_d1_q && !abort_c;
        frame_abort_d    = abort_c;
        pend_ovf_d       = 1'b0;

        case (state_q)
            R_IDLE: begin
                if (start_c) begin
                    state_d     = R_READ;
                    rd_cnt_d    = '0;
                    frame_len_d = byte_num_q;
                end
            end
            R_READ: begin
                if (abort_c) begin
                    state_d = R_IDLE;
                end else if (rd_en_c) begin
                    rd_cnt_d = rd_cnt_q + CNT_W'(1);
                    if (last_rd_c) begin
                        state_d = R_DRAIN;
                        drain_d = 1'b0;
                    end
                end
            end
            R_DRAIN: begin
                if (abort_c || drain_q) begin
                    state_d = R_IDLE;
                end else begin
                    drain_d = 1'b1;
                end
            end
            default: state_d = R_IDLE;
        endcase

        // Pending frames: any gear change flushes, and a take offsets a new arrival.
        if (gear_chg_c) begin
            pend_cnt_d = '0;
        end else if (wr_ml_end && !take_c) begin
            if (pend_cnt_q == PEND_MAX) begin
                pend_ovf_d = 1'b1;
            end else begin
                pend_cnt_d = pend_cnt_q + PEND_W'(1);
            end
        end else if (!wr_ml_end && take_c) begin
            pend_cnt_d = pend_cnt_q - PEND_W'(1);
        end

        rd_busy_d = (state_d != R_IDLE);
    end

    always_ff @(posedge clk163m84) begin
        if (!rst_n) begin
            state_q          <= R_IDLE;
            byte_num_q       <= '0;
            frame_len_q      <= '0;
            rd_cnt_q         <= '0;
            pend_cnt_q       <= '0;
            drain_q          <= 1'b0;
            rd_en_d1_q       <= 1'b0;
            last_d1_q        <= 1'b0;
            data_out_q       <= '0;
            data_out_valid_q <= 1'b0;
            frame_start_q    <= 1'b0;
            frame_end_q      <= 1'b0;
            frame_abort_q    <= 1'b0;
            pend_ovf_q       <= 1'b0;
            rd_busy_q        <= 1'b0;
        end else begin
            state_q          <= state_d;
            byte_num_q       <= byte_num_d;
            frame_len_q      <= frame_len_d;
            rd_cnt_q         <= rd_cnt_d;
            pend_cnt_q       <= pend_cnt_d;
            drain_q          <= drain_d;
            rd_en_d1_q       <= rd_en_d1_d;
            last_d1_q        <= last_d1_d;
            data_out_q       <= data_out_d;
            data_out_valid_q <= data_out_valid_d;
            frame_start_q    <= frame_start_d;
            frame_end_q      <= frame_end_d;
            frame_abort_q    <= frame_abort_d;
            pend_ovf_q       <= pend_ovf_d;
            rd_busy_q        <= rd_busy_d;
        end
    end

    assign fifo_rd_en     = rd_en_c;
    assign data_out       = data_out_q;
    assign data_out_valid = data_out_valid_q;
    assign frame_start    = frame_start_q;
    assign frame_end      = frame_end_q;
    assign frame_abort    = frame_abort_q;
    assign pend_ovf       = pend_ovf_q;
    assign rd_busy        = rd_busy_q;

endmodule
